// File: rtl/program_load_controller_pkg.sv
// rtl/program_load_controller_pkg.sv - shared data width and loader state encoding
package program_load_controller_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_DATA    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5,
    ST_TIMEOUT = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_t;

endpackage

// File: rtl/program_load_controller_if.sv
// rtl/program_load_controller_if.sv - byte stream, RAM write port, CPU control and status bundle
interface program_load_controller_if
  import program_load_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) ();

  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  cpu_reset;
  logic                  cpu_halt;
  logic [DATA_WIDTH-1:0] cpu_out;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  err;
  logic [DATA_WIDTH-1:0] result;

  // Controller side
  modport master (
    input  start, in_valid, in_data, cpu_halt, cpu_out,
    output in_ready, ram_we, ram_addr, ram_wdata, cpu_reset,
    output busy, done, timeout, err, result
  );

  // Byte source, RAM and CPU side
  modport slave (
    output start, in_valid, in_data, cpu_halt, cpu_out,
    input  in_ready, ram_we, ram_addr, ram_wdata, cpu_reset,
    input  busy, done, timeout, err, result
  );

endinterface

// File: rtl/program_load_controller.sv
// rtl/program_load_controller.sv - loads a length-prefixed program into RAM, then runs the CPU to halt or timeout
module program_load_controller
  import program_load_controller_pkg::*;
#(
  parameter int ADDR_WIDTH        = 4,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int MAX_RUN_CYCLES    = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  program_load_controller_if.master bus
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD_CYCLES);
  localparam logic [31:0] RUN_LAST  = 32'(MAX_RUN_CYCLES - 1);

  loader_state_t         state_q;
  logic                  in_ready_q;
  logic                  ram_we_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  cpu_reset_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] remaining_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           hold_cnt_q;
  logic [31:0]           run_cnt_q;

  logic xfer;
  logic len_bad;

  // A byte moves only when the source offers it and we advertised readiness
  assign xfer    = bus.in_valid && in_ready_q;
  // Zero-length programs and programs longer than the RAM are rejected
  assign len_bad = (bus.in_data == '0) || (32'(bus.in_data) > 32'(DEPTH));

  // Loader sequencer: length, data writes, reset hold, run watch, sticky result states
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      hold_cnt_q  <= '0;
      run_cnt_q   <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT, ST_ERROR: begin
          if (bus.start) begin
            state_q     <= ST_LEN;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            if (len_bad) begin
              state_q    <= ST_ERROR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q     <= ST_DATA;
              remaining_q <= bus.in_data;
              idx_q       <= '0;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= idx_q;
            ram_wdata_q <= bus.in_data;
            idx_q       <= idx_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - DATA_WIDTH'(1);
            // Last byte: stop accepting now so the final write lands in the first HOLD cycle
            if (remaining_q == DATA_WIDTH'(1)) begin
              state_q    <= ST_HOLD;
              in_ready_q <= 1'b0;
              hold_cnt_q <= '0;
            end
          end
        end
        ST_HOLD: begin
          // The first HOLD cycle carries the final write; the hold count starts after it
          if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
            run_cnt_q   <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 32'd1;
          end
        end
        ST_RUN: begin
          // Halt is checked first so it wins over a limit reached in the same cycle
          if (bus.cpu_halt) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= bus.cpu_out;
          end else if (run_cnt_q == RUN_LAST) begin
            state_q     <= ST_TIMEOUT;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b1;
            cpu_reset_q <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_program_load_controller.sv
// tb/tb_program_load_controller.sv - randomized bench against a transaction-level loader model
module tb_program_load_controller;
  import program_load_controller_pkg::*;

  localparam int AW    = 4;
  localparam int HOLD  = 2;
  localparam int MAXR  = 50;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  program_load_controller_if #(.ADDR_WIDTH(AW)) bus ();

  program_load_controller #(
    .ADDR_WIDTH       (AW),
    .RESET_HOLD_CYCLES(HOLD),
    .MAX_RUN_CYCLES   (MAXR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  wr_t        exp_q[$];
  int         rd_ptr   = 0;
  logic [7:0] tb_ram [DEPTH];
  logic [7:0] prog[$];
  int         wr_count;
  int         run_cycles;
  int         rel_cyc;
  int         last_we_cyc;
  int         halt_at;
  logic [7:0] halt_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: observe RAM writes and play the CPU at negedge, then step past posedge
  task automatic tick();
    bit due;
    @(negedge clk);
    due = (rd_ptr < exp_q.size()) && (exp_q[rd_ptr].cyc == cyc);
    if (bus.ram_we || due) begin
      chk("ram_we", 32'(bus.ram_we), 32'(due));
      if (due) begin
        chk("ram_addr", 32'(bus.ram_addr), 32'(exp_q[rd_ptr].addr));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(exp_q[rd_ptr].data));
        rd_ptr++;
      end
      if (bus.ram_we) begin
        tb_ram[bus.ram_addr] = bus.ram_wdata;
        wr_count++;
        last_we_cyc = cyc;
      end
    end
    if (!bus.cpu_reset && !bus.done && !bus.timeout) begin
      if (rel_cyc < 0) rel_cyc = cyc;
      bus.cpu_halt = (run_cycles == halt_at);
      bus.cpu_out  = bus.cpu_halt ? halt_val : 8'($urandom);
      run_cycles++;
    end else begin
      bus.cpu_halt = 1'($urandom_range(0, 1));
      bus.cpu_out  = 8'($urandom);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
  endtask

  // Offer the first n bytes of prog; mode 0 = valid held, 1 = every other cycle, 2 = random
  task automatic send_bytes(input int mode, input int n);
    int i;
    int guard;
    bit v;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? prog[i] : 8'($urandom);
      if (v && bus.in_ready) begin
        if (i > 0) exp_q.push_back('{cyc + 1, i - 1, int'(prog[i])});
        i++;
      end
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < n) chk("send_stalled", 32'(i), 32'(n));
  endtask

  // Full load-and-run transaction; n_lim >= 0 stops the stream early (caller then resets)
  task automatic run_prog(input int mode, input int n_lim, input int h_at,
                          input logic [7:0] h_val, input bit poke);
    int len;
    bit ok_len;
    int full;
    int n;
    bit exp_done;
    int exp_runs;
    int guard;
    bit poked;
    len    = int'(prog[0]);
    ok_len = (len != 0) && (len <= DEPTH);
    full   = ok_len ? len + 1 : 1;
    n      = (n_lim >= 0 && n_lim < full) ? n_lim : full;
    halt_at     = h_at;
    halt_val    = h_val;
    wr_count    = 0;
    run_cycles  = 0;
    rel_cyc     = -1;
    last_we_cyc = -1;

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    chk("start_flags", 32'({bus.done, bus.timeout, bus.err}), 32'd0);
    chk("start_result", 32'(bus.result), 32'd0);
    chk("start_cpu_reset", 32'(bus.cpu_reset), 32'd1);

    send_bytes(mode, n);
    if (n < full) return;

    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      chk("in_ready_after_load", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;

    if (!ok_len) begin
      chk("err_flag", 32'(bus.err), 32'd1);
      chk("err_busy", 32'(bus.busy), 32'd0);
      chk("err_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      chk("err_in_ready", 32'(bus.in_ready), 32'd0);
      chk("err_no_writes", 32'(wr_count), 32'd0);
      chk("err_done", 32'(bus.done), 32'd0);
      return;
    end

    exp_done = (halt_at <= MAXR - 1);
    exp_runs = exp_done ? halt_at + 1 : MAXR;
    guard = 0;
    poked = 1'b0;
    while (!(bus.done || bus.timeout) && guard < MAXR + 40) begin
      if (poke && !poked && run_cycles == 3) begin
        poked = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("run_start_busy", 32'(bus.busy), 32'd1);
        chk("run_start_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        chk("run_start_in_ready", 32'(bus.in_ready), 32'd0);
      end else begin
        tick();
      end
      guard++;
    end

    chk("end_done", 32'(bus.done), 32'(exp_done));
    chk("end_timeout", 32'(bus.timeout), 32'(!exp_done));
    chk("end_err", 32'(bus.err), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_cpu_reset", 32'(bus.cpu_reset), 32'(!exp_done));
    chk("run_cycles", 32'(run_cycles), 32'(exp_runs));
    chk("release_gap", 32'(rel_cyc - last_we_cyc), 32'(HOLD + 1));
    chk("write_count", 32'(wr_count), 32'(len));
    chk("end_result", 32'(bus.result), exp_done ? 32'(halt_val) : 32'd0);
    for (int k = 0; k < len; k++) chk("ram_content", 32'(tb_ram[k]), 32'(prog[k + 1]));
    tick();
    tick();
    chk("sticky_done", 32'(bus.done), 32'(exp_done));
    chk("sticky_timeout", 32'(bus.timeout), 32'(!exp_done));
    chk("sticky_result", 32'(bus.result), exp_done ? 32'(halt_val) : 32'd0);
  endtask

  initial begin
    int len;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.cpu_halt = 1'b0;
    bus.cpu_out  = 8'h00;
    for (int i = 0; i < DEPTH; i++) tb_ram[i] = 8'h00;
    halt_at     = 0;
    halt_val    = 8'h00;
    wr_count    = 0;
    run_cycles  = 0;
    rel_cyc     = -1;
    last_we_cyc = -1;

    @(posedge clk);
    #1;
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();

    // Directed: held valid, toggled valid, bad lengths, timeout, halt on limit cycle
    prog = '{8'h03, 8'h51, 8'h08, 8'hF0};
    run_prog(0, -1, 5, 8'h08, 1'b0);
    run_prog(1, -1, 7, 8'h08, 1'b0);
    prog = '{8'h00};
    run_prog(0, -1, 5, 8'h00, 1'b0);
    prog = '{8'h11};
    run_prog(1, -1, 5, 8'h00, 1'b0);
    prog.delete();
    prog.push_back(8'(DEPTH));
    for (int k = 0; k < DEPTH; k++) prog.push_back(8'($urandom));
    run_prog(2, -1, 1000, 8'h00, 1'b0);
    prog = '{8'h02, 8'hA5, 8'h5A};
    run_prog(0, -1, MAXR - 1, 8'h3C, 1'b0);

    // Reset after two of four data bytes, then a full load with a start pulse during RUN
    prog = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    run_prog(0, 3, 10, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_state();
    reset = 1'b0;
    tick();
    run_prog(0, -1, 10, 8'hC3, 1'b1);

    // Randomized programs, lengths straddling both illegal boundaries
    for (int t = 0; t < 10; t++) begin
      len = int'($urandom_range(0, DEPTH + 2));
      prog.delete();
      prog.push_back(8'(len));
      for (int k = 0; k < len; k++) prog.push_back(8'($urandom));
      run_prog(int'($urandom_range(0, 2)), -1, int'($urandom_range(0, MAXR + 5)),
               8'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
